// File: rtl/fc_layer_seq.sv
// fc_layer_seq: FC-layer address/strobe sequencer for the LeNet-5 MAC path.
// Ports: clk, rst (async, active-high), en in; done, in_addr, w_addr,
// b_addr, rd_en, mac_valid, mac_first, mac_last, out_we, out_addr out.
// Optional macro FC_PERF_CNT_EN adds busy_cycles (RUN+DRAIN cycle count).
module fc_layer_seq #(
  parameter int N_IN   = 120,
  parameter int N_OUT  = 84,
  parameter int IA_W   = 7,
  parameter int OA_W   = 7,
  parameter int WA_W   = 14,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic            done,
  output logic [IA_W-1:0] in_addr,
  output logic [WA_W-1:0] w_addr,
  output logic [OA_W-1:0] b_addr,
  output logic            rd_en,
  output logic            mac_valid,
  output logic            mac_first,
  output logic            mac_last,
  output logic            out_we,
  output logic [OA_W-1:0] out_addr
`ifdef FC_PERF_CNT_EN
  ,
  output logic [31:0]     busy_cycles
`endif
);

  if (N_IN < 2 || N_OUT < 1 || RD_LAT < 1 || RD_LAT > 3 ||
      (1 << IA_W) < N_IN || (1 << OA_W) < N_OUT ||
      (1 << WA_W) < N_IN * N_OUT) begin : g_param_err
    $error("fc_layer_seq: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q;

  logic [IA_W-1:0] i_cnt_q, i_cnt_d;
  logic [OA_W-1:0] o_cnt_q, o_cnt_d;
  logic [WA_W-1:0] w_cnt_q, w_cnt_d;
  logic [1:0]      d_cnt_q;

  logic [IA_W-1:0] ia_q;
  logic [WA_W-1:0] wa_q;

  // Stage 0 is the issue register; stage RD_LAT lines up with RAM data.
  logic [RD_LAT:0]           vld_q;
  logic [RD_LAT:0]           fst_q;
  logic [RD_LAT:0]           lst_q;
  logic [RD_LAT:0][OA_W-1:0] oc_q;

  logic            we_q;
  logic [OA_W-1:0] oa_q;
  logic            done_q;

  logic i_last, o_last, abort;

  assign i_last = (i_cnt_q == IA_W'(N_IN - 1));
  assign o_last = (o_cnt_q == OA_W'(N_OUT - 1));
  assign abort  = ~en && (state_q != S_IDLE);

  always_comb begin
    i_cnt_d = i_last ? '0 : i_cnt_q + 1'b1;
    o_cnt_d = o_cnt_q;
    if (i_last) o_cnt_d = o_last ? '0 : o_cnt_q + 1'b1;
    w_cnt_d = (i_last && o_last) ? '0 : w_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_cnt_q <= '0;
      o_cnt_q <= '0;
      w_cnt_q <= '0;
      d_cnt_q <= '0;
      ia_q    <= '0;
      wa_q    <= '0;
      vld_q   <= '0;
      fst_q   <= '0;
      lst_q   <= '0;
      oc_q    <= '0;
      we_q    <= 1'b0;
      oa_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      vld_q[0] <= 1'b0;
      fst_q[0] <= 1'b0;
      lst_q[0] <= 1'b0;
      oc_q[0]  <= '0;
      ia_q     <= '0;
      wa_q     <= '0;
      for (int k = 1; k <= RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        fst_q[k] <= fst_q[k-1];
        lst_q[k] <= lst_q[k-1];
        oc_q[k]  <= oc_q[k-1];
      end
      // One cycle of MAC accumulate latency before the result is writable.
      we_q <= vld_q[RD_LAT] & lst_q[RD_LAT];
      oa_q <= (vld_q[RD_LAT] & lst_q[RD_LAT]) ? oc_q[RD_LAT] : '0;

      if (abort) begin
        state_q <= S_IDLE;
        i_cnt_q <= '0;
        o_cnt_q <= '0;
        w_cnt_q <= '0;
        d_cnt_q <= '0;
        vld_q   <= '0;
        fst_q   <= '0;
        lst_q   <= '0;
        oc_q    <= '0;
        we_q    <= 1'b0;
        oa_q    <= '0;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (en) begin
              state_q <= S_RUN;
              i_cnt_q <= '0;
              o_cnt_q <= '0;
              w_cnt_q <= '0;
            end
          end
          S_RUN: begin
            vld_q[0] <= 1'b1;
            fst_q[0] <= (i_cnt_q == '0);
            lst_q[0] <= i_last;
            oc_q[0]  <= o_cnt_q;
            ia_q     <= i_cnt_q;
            wa_q     <= w_cnt_q;
            i_cnt_q  <= i_cnt_d;
            o_cnt_q  <= o_cnt_d;
            w_cnt_q  <= w_cnt_d;
            if (i_last && o_last) begin
              state_q <= S_DRAIN;
              d_cnt_q <= '0;
            end
          end
          S_DRAIN: begin
            if (d_cnt_q == 2'(RD_LAT)) state_q <= S_DONE;
            else d_cnt_q <= d_cnt_q + 1'b1;
          end
          S_DONE: done_q <= 1'b1;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign done      = done_q;
  assign rd_en     = vld_q[0];
  assign in_addr   = ia_q;
  assign w_addr    = wa_q;
  assign b_addr    = oc_q[0];
  assign mac_valid = vld_q[RD_LAT];
  assign mac_first = fst_q[RD_LAT];
  assign mac_last  = lst_q[RD_LAT];
  assign out_we    = we_q;
  assign out_addr  = oa_q;

`ifdef FC_PERF_CNT_EN
  logic [31:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (state_q == S_IDLE && en) busy_d = '0;
    else if (state_q == S_RUN || state_q == S_DRAIN) busy_d = busy_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: randomized bench for fc_layer_seq, two configurations
// (4x3 RD_LAT=1 and 2x2 RD_LAT=3) checked every cycle against a model.
module tb_fc_layer_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  always #5 clk = ~clk;

  logic done_a, rd_a, mv_a, mf_a, ml_a, we_a;
  logic [6:0] ia_a, ba_a, oa_a;
  logic [13:0] wa_a;
  logic done_b, rd_b, mv_b, mf_b, ml_b, we_b;
  logic [6:0] ia_b, ba_b, oa_b;
  logic [13:0] wa_b;
`ifdef FC_PERF_CNT_EN
  logic [31:0] busy_a, busy_b;
`endif

  fc_layer_seq #(
    .N_IN(4), .N_OUT(3), .IA_W(7), .OA_W(7), .WA_W(14), .RD_LAT(1)
  ) u_a (
    .clk(clk), .rst(rst), .en(en_a), .done(done_a),
    .in_addr(ia_a), .w_addr(wa_a), .b_addr(ba_a), .rd_en(rd_a),
    .mac_valid(mv_a), .mac_first(mf_a), .mac_last(ml_a),
    .out_we(we_a), .out_addr(oa_a)
`ifdef FC_PERF_CNT_EN
    , .busy_cycles(busy_a)
`endif
  );

  fc_layer_seq #(
    .N_IN(2), .N_OUT(2), .IA_W(7), .OA_W(7), .WA_W(14), .RD_LAT(3)
  ) u_b (
    .clk(clk), .rst(rst), .en(en_b), .done(done_b),
    .in_addr(ia_b), .w_addr(wa_b), .b_addr(ba_b), .rd_en(rd_b),
    .mac_valid(mv_b), .mac_first(mf_b), .mac_last(ml_b),
    .out_we(we_b), .out_addr(oa_b)
`ifdef FC_PERF_CNT_EN
    , .busy_cycles(busy_b)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  int rst_cnt = 1;
  int base_a = 0, ab_a = 0, st_a = 0, run_a = 0;
  int base_b = 0, ab_b = 0, st_b = 0, run_b = 0;
  int ka, kb;

  // Expected outputs at cycle k after the start edge; all zero from ab on.
  function automatic logic [40:0] exp_vec(int k, int ni, int no,
                                          int lat, int ab);
    int n, j, m;
    logic d, re, mv, mf, ml, we;
    logic [6:0] ia, ba, oa;
    logic [13:0] wa;
    n = ni * no;
    {d, re, mv, mf, ml, we} = '0;
    ia = '0; ba = '0; oa = '0; wa = '0;
    if (k >= 0 && k < ab) begin
      if (k >= 1 && k <= n) begin
        j = k - 1;
        re = 1'b1;
        ia = 7'(j % ni);
        wa = 14'(j);
        ba = 7'(j / ni);
      end
      m = k - 1 - lat;
      if (m >= 0 && m < n) begin
        mv = 1'b1;
        mf = (m % ni == 0);
        ml = (m % ni == ni - 1);
      end
      m = k - 2 - lat;
      if (m >= 0 && m < n && m % ni == ni - 1) begin
        we = 1'b1;
        oa = 7'(m / ni);
      end
      d = (k >= n + lat + 2);
    end
    return {d, re, mv, mf, ml, we, ia, wa, ba, oa};
  endfunction

  function automatic int exp_busy(int k, int ab, int lim, int stale);
    int v;
    if (stale != 0) return 0;
    v = (k < ab) ? k : ab;
    return (v < lim) ? v : lim;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    ka = cyc - base_a;
    kb = cyc - base_b;
    check("A_cycle",
          64'({done_a, rd_a, mv_a, mf_a, ml_a, we_a, ia_a, wa_a, ba_a, oa_a}),
          64'(exp_vec(ka, 4, 3, 1, ab_a)));
    check("B_cycle",
          64'({done_b, rd_b, mv_b, mf_b, ml_b, we_b, ia_b, wa_b, ba_b, oa_b}),
          64'(exp_vec(kb, 2, 2, 3, ab_b)));
`ifdef FC_PERF_CNT_EN
    check("A_busy", 64'(busy_a),
          64'(exp_busy(ka, ab_a, 14, int'(rst_cnt != st_a))));
    check("B_busy", 64'(busy_b),
          64'(exp_busy(kb, ab_b, 8, int'(rst_cnt != st_b))));
    if (run_a == 1 && ka == 15) check("A_busy_at_done", 64'(busy_a), 64'd14);
`endif
    if (run_a == 1) begin
      if (ka == 12) check("A_last_issue", 64'({rd_a, wa_a}), 64'({1'b1, 14'd11}));
      if (ka == 13) check("A_last_mac", 64'({mv_a, ml_a}), 64'd3);
      if (ka == 14) check("A_final_we", 64'({we_a, oa_a, done_a}),
                          64'({1'b1, 7'd2, 1'b0}));
      if (ka == 15) check("A_done_rise", 64'(done_a), 64'd1);
    end
    if (run_a == 2 && ka == 1)
      check("A_restart_w0", 64'({rd_a, wa_a}), 64'({1'b1, 14'd0}));
    if (run_b == 1) begin
      if (kb == 4) check("B_first_mac", 64'({mv_b, mf_b}), 64'd3);
      if (kb == 8) check("B_done_low", 64'(done_b), 64'd0);
      if (kb == 9) check("B_done_rise", 64'(done_b), 64'd1);
    end
  end

  task automatic start_a();
    en_a = 1'b1;
    base_a = cyc + 1;
    ab_a = 1 << 30;
    st_a = rst_cnt;
    run_a++;
  endtask

  task automatic drop_a();
    en_a = 1'b0;
    ab_a = cyc + 1 - base_a;
  endtask

  task automatic start_b();
    en_b = 1'b1;
    base_b = cyc + 1;
    ab_b = 1 << 30;
    st_b = rst_cnt;
    run_b++;
  endtask

  task automatic drop_b();
    en_b = 1'b0;
    ab_b = cyc + 1 - base_b;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    start_b();
    repeat (13) @(negedge clk);
    drop_b();
    repeat (3) @(negedge clk);
    start_b();
    repeat ($urandom_range(1, 8)) @(negedge clk);
    drop_b();
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_a();
    repeat (21) @(negedge clk);
    drop_a();
    repeat (3) @(negedge clk);
    start_a();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    rst_cnt++;
    ab_a = cyc - base_a;
    #1;
    check("A_async_rst", 64'({rd_a, wa_a, ia_a, mv_a, we_a}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_a();
    repeat (21) @(negedge clk);
    drop_a();
    repeat (2) @(negedge clk);
    start_a();
    repeat (6) @(negedge clk);
    drop_a();
    repeat (3) @(negedge clk);
    for (int r = 0; r < 12; r++) begin
      start_a();
      repeat ($urandom_range(1, 22)) @(negedge clk);
      drop_a();
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    repeat (25) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
